// File: rtl/pipeline_ctrl_if.sv
// -----------------------------------------------------------------------------
// buffer_load_mux package and pipeline_ctrl_if interface.
//
// buffer_load_mux::buffer_sel_t is the select code that each pipeline buffer's
// load mux understands: keep the old contents, or load from a named stage.
//
// pipeline_ctrl_if bundles every signal between the pipeline datapath and the
// hazard/stall controller:
//   datapath -> controller : imem_read, imem_resp, dmem_req, dmem_resp,
//                            load_use, br_mispredict
//   controller -> datapath : load_pc, load_ifid, load_idex, load_exmem,
//                            load_memwb, sel_ifid, sel_idex, sel_exmem,
//                            sel_memwb, bubble_ifid, bubble_idex,
//                            stall_cnt, flush_cnt, bubble_cnt
// modport master : the datapath side
// modport slave  : the controller side
// -----------------------------------------------------------------------------
package buffer_load_mux;
  typedef enum logic [2:0] {
    USE_OLD    = 3'd0,
    LOAD_IFID  = 3'd1,
    LOAD_IDEX  = 3'd2,
    LOAD_EXMEM = 3'd3,
    LOAD_MEMWB = 3'd4
  } buffer_sel_t;
endpackage

interface pipeline_ctrl_if;
  import buffer_load_mux::*;

  // Datapath status
  logic        imem_read;
  logic        imem_resp;
  logic        dmem_req;
  logic        dmem_resp;
  logic        load_use;
  logic        br_mispredict;

  // Register enables
  logic        load_pc;
  logic        load_ifid;
  logic        load_idex;
  logic        load_exmem;
  logic        load_memwb;

  // Buffer load-mux selects
  buffer_sel_t sel_ifid;
  buffer_sel_t sel_idex;
  buffer_sel_t sel_exmem;
  buffer_sel_t sel_memwb;

  // Zero-packet injection
  logic        bubble_ifid;
  logic        bubble_idex;

  // Performance counters
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic [31:0] bubble_cnt;

  modport master (
    output imem_read, imem_resp, dmem_req, dmem_resp, load_use, br_mispredict,
    input  load_pc, load_ifid, load_idex, load_exmem, load_memwb,
    input  sel_ifid, sel_idex, sel_exmem, sel_memwb,
    input  bubble_ifid, bubble_idex,
    input  stall_cnt, flush_cnt, bubble_cnt
  );

  modport slave (
    input  imem_read, imem_resp, dmem_req, dmem_resp, load_use, br_mispredict,
    output load_pc, load_ifid, load_idex, load_exmem, load_memwb,
    output sel_ifid, sel_idex, sel_exmem, sel_memwb,
    output bubble_ifid, bubble_idex,
    output stall_cnt, flush_cnt, bubble_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl -- stall / flush / bubble controller for a 5-stage pipeline.
//
// The whole pipeline advances only when every outstanding memory access has
// been answered. An icache or dcache response that arrives while the other
// side is still busy is remembered in a sticky flag (i_done / d_done) so that
// it is not lost; both flags clear on the cycle the pipeline finally advances.
// On an advance cycle a load-use hazard freezes PC and IF/ID and injects a
// bubble into ID/EX; a branch mispredict redirects the PC and squashes IF/ID
// and ID/EX, taking priority over load-use.
//
// Ports:
//   clk  : single clock, all state changes on its rising edge
//   rst  : asynchronous active-low reset (asserts at once, released on clk)
//   bus  : pipeline_ctrl_if.slave (status in, enables/selects/counters out)
//
// Configuration:
//   PIPELINE_CTRL_PERF_EN : when defined, stall/flush/bubble counters
//                           (saturating, 32 bit) are built; otherwise the
//                           counter outputs are tied to zero.
//
// The enables, selects and bubbles are combinational from the current state
// and inputs, so the datapath sees them in the same cycle the hazard appears.
// -----------------------------------------------------------------------------
module pipeline_ctrl
  import buffer_load_mux::*;
(
  input  logic            clk,
  input  logic            rst,
  pipeline_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    INIT = 2'd0,  // one cycle after reset, pipeline held
    RUN  = 2'd1,  // advancing
    WAIT = 2'd2   // held, waiting on a memory response
  } state_t;

  state_t state;
  logic   i_done;
  logic   d_done;

  logic   i_ok;
  logic   d_ok;
  logic   advance;
  logic   redirect;
  logic   hold_front;

  // A side is satisfied if it has nothing outstanding, answers this cycle,
  // or already answered during an earlier held cycle.
  assign i_ok    = ~bus.imem_read | bus.imem_resp | i_done;
  assign d_ok    = ~bus.dmem_req  | bus.dmem_resp | d_done;
  assign advance = (state != INIT) & i_ok & d_ok;

  // Hazards only matter on cycles where the pipeline actually moves;
  // mispredict wins over load-use because the stalled instruction is
  // being squashed anyway.
  assign redirect   = advance & bus.br_mispredict;
  assign hold_front = advance & bus.load_use & ~bus.br_mispredict;

  // ---------------------------------------------------------------------------
  // State and sticky response flags
  // ---------------------------------------------------------------------------
  // NOTE: asynchronous active-low reset sits in the sensitivity list so the
  // controller drops to INIT the moment rst falls, without waiting for clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= INIT;
      i_done <= 1'b0;
      d_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values of advance/state, independent of statement order.
      unique case (state)
        INIT:    state <= RUN;
        RUN:     state <= advance ? RUN : WAIT;
        WAIT:    state <= advance ? RUN : WAIT;
        default: state <= INIT;
      endcase

      if (advance) begin
        i_done <= 1'b0;
        d_done <= 1'b0;
      end else begin
        if (bus.imem_resp) i_done <= 1'b1;
        if (bus.dmem_resp) d_done <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Enables, mux selects and bubble controls
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default first so no path through the
    // if/else chain leaves one unassigned (which would infer a latch).
    bus.load_pc     = 1'b0;
    bus.load_ifid   = 1'b0;
    bus.load_idex   = 1'b0;
    bus.load_exmem  = 1'b0;
    bus.load_memwb  = 1'b0;
    bus.sel_ifid    = USE_OLD;
    bus.sel_idex    = USE_OLD;
    bus.sel_exmem   = USE_OLD;
    bus.sel_memwb   = USE_OLD;
    bus.bubble_ifid = 1'b0;
    bus.bubble_idex = 1'b0;

    if (advance) begin
      // Back end always moves on an advance cycle.
      bus.load_idex  = 1'b1;
      bus.load_exmem = 1'b1;
      bus.load_memwb = 1'b1;
      bus.sel_idex   = LOAD_IDEX;
      bus.sel_exmem  = LOAD_EXMEM;
      bus.sel_memwb  = LOAD_MEMWB;

      if (redirect) begin
        // PC takes the redirect target; the two younger packets are wrong-path.
        bus.load_pc     = 1'b1;
        bus.load_ifid   = 1'b1;
        bus.sel_ifid    = LOAD_IFID;
        bus.bubble_ifid = 1'b1;
        bus.bubble_idex = 1'b1;
      end else if (hold_front) begin
        // Keep the dependent instruction in ID; EX receives a bubble.
        bus.bubble_idex = 1'b1;
      end else begin
        bus.load_pc   = 1'b1;
        bus.load_ifid = 1'b1;
        bus.sel_ifid  = LOAD_IFID;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;
  logic [31:0] bubble_q;
  logic        stall_evt;

  // INIT is a reset artefact, not a memory stall.
  assign stall_evt = (state != INIT) & ~advance;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q  <= '0;
      flush_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (stall_evt  && stall_q  != 32'hFFFF_FFFF) stall_q  <= stall_q  + 32'd1;
      if (redirect   && flush_q  != 32'hFFFF_FFFF) flush_q  <= flush_q  + 32'd1;
      if (hold_front && bubble_q != 32'hFFFF_FFFF) bubble_q <= bubble_q + 32'd1;
    end
  end

  assign bus.stall_cnt  = stall_q;
  assign bus.flush_cnt  = flush_q;
  assign bus.bubble_cnt = bubble_q;
`else
  assign bus.stall_cnt  = '0;
  assign bus.flush_cnt  = '0;
  assign bus.bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl -- self-checking bench for pipeline_ctrl.
//
// A behavioural model tracks "cycles since reset", which memory answers have
// already been seen, and event totals; every falling clock edge the DUT
// outputs are compared against what that model says they must be. Directed
// scenarios additionally check hand-computed literal values at key cycles.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

`ifdef PIPELINE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_on = 1'b0;

  always #5 clk = ~clk;

  pipeline_ctrl_if bus ();

  pipeline_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [4:0]  loads;
  logic [11:0] sels;
  logic [1:0]  bubs;
  assign loads = {bus.load_pc, bus.load_ifid, bus.load_idex, bus.load_exmem, bus.load_memwb};
  assign sels  = {bus.sel_ifid, bus.sel_idex, bus.sel_exmem, bus.sel_memwb};
  assign bubs  = {bus.bubble_ifid, bus.bubble_idex};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  bit          m_first;         // first cycle after reset: pipeline held
  bit          m_got_i, m_got_d; // answer already received during a hold
  longint      m_stall, m_flush, m_bub;

  function automatic bit m_moves();
    bit i_sat, d_sat;
    i_sat = !bus.imem_read || bus.imem_resp || m_got_i;
    d_sat = !bus.dmem_req  || bus.dmem_resp || m_got_d;
    return !m_first && i_sat && d_sat;
  endfunction

  // Expected {loads, sels, bubbles}.
  function automatic logic [18:0] m_outputs();
    logic [4:0]  l;
    logic [11:0] s;
    logic [1:0]  b;
    l = 5'b00000; s = 12'h000; b = 2'b00;
    if (m_moves()) begin
      if (bus.br_mispredict) begin
        l = 5'b11111; s = {3'd1, 3'd2, 3'd3, 3'd4}; b = 2'b11;
      end else if (bus.load_use) begin
        l = 5'b00111; s = {3'd0, 3'd2, 3'd3, 3'd4}; b = 2'b01;
      end else begin
        l = 5'b11111; s = {3'd1, 3'd2, 3'd3, 3'd4}; b = 2'b00;
      end
    end
    return {l, s, b};
  endfunction

  function automatic logic [31:0] sat32(input longint v);
    return (v > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_first = 1'b1; m_got_i = 1'b0; m_got_d = 1'b0;
      m_stall = 0; m_flush = 0; m_bub = 0;
    end else begin
      if (m_moves()) begin
        if (bus.br_mispredict) m_flush++;
        else if (bus.load_use) m_bub++;
        m_got_i = 1'b0; m_got_d = 1'b0;
      end else begin
        if (!m_first) m_stall++;
        if (bus.imem_resp) m_got_i = 1'b1;
        if (bus.dmem_resp) m_got_d = 1'b1;
      end
      m_first = 1'b0;
    end
  end

  // Compare process: outputs are settled by the falling edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      logic [18:0] e;
      e = m_outputs();
      check("model_loads",   {27'd0, loads}, {27'd0, e[18:14]});
      check("model_sels",    {20'd0, sels},  {20'd0, e[13:2]});
      check("model_bubbles", {30'd0, bubs},  {30'd0, e[1:0]});
      check("model_stall_cnt",  bus.stall_cnt,  PERF ? sat32(m_stall) : 32'd0);
      check("model_flush_cnt",  bus.flush_cnt,  PERF ? sat32(m_flush) : 32'd0);
      check("model_bubble_cnt", bus.bubble_cnt, PERF ? sat32(m_bub)   : 32'd0);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic drive(input bit ir, input bit is, input bit dq, input bit ds,
                       input bit lu, input bit br);
    bus.imem_read = ir; bus.imem_resp = is;
    bus.dmem_req  = dq; bus.dmem_resp = ds;
    bus.load_use  = lu; bus.br_mispredict = br;
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    next_cycle();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    next_cycle();
  endtask

  localparam logic [11:0] SEL_ALL = {3'd1, 3'd2, 3'd3, 3'd4};

  // Mixed-traffic vectors {imem_read, imem_resp, dmem_req, dmem_resp, load_use, br}
  localparam int NV = 20;
  logic [5:0] vec [NV] = '{
    6'b100000, 6'b110000, 6'b101000, 6'b100100, 6'b001100,
    6'b111100, 6'b000010, 6'b101010, 6'b000110, 6'b100001,
    6'b110011, 6'b001000, 6'b000000, 6'b010001, 6'b101101,
    6'b000011, 6'b111010, 6'b100000, 6'b010000, 6'b000000
  };

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    #1 rst = 1'b0;
    next_cycle();
    cmp_on = 1'b1;

    // Reset state
    #1;
    check("reset_loads", {27'd0, loads}, 32'd0);
    check("reset_sels",  {20'd0, sels},  32'd0);
    check("reset_cnt",   bus.stall_cnt | bus.flush_cnt | bus.bubble_cnt, 32'd0);

    // Free-running fetch: INIT holds, then everything advances
    next_cycle();
    drive(1, 1, 0, 0, 0, 0); rst = 1'b1;
    #1 check("fetch_c0_loads", {27'd0, loads}, 32'd0);
    next_cycle();
    #1 check("fetch_c1_loads", {27'd0, loads}, 32'h1f);
    check("fetch_c1_sel_idex", {29'd0, bus.sel_idex}, 32'd2);
    check("fetch_c1_sels", {20'd0, sels}, {20'd0, SEL_ALL});
    next_cycle();
    #1 check("fetch_c2_loads", {27'd0, loads}, 32'h1f);

    // Dcache miss answered at cycle 4
    apply_reset();
    drive(0, 0, 1, 0, 0, 0); rst = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      #1 check("dmiss_hold_loads", {27'd0, loads}, 32'd0);
    end
    next_cycle();
    bus.dmem_resp = 1'b1;
    #1 check("dmiss_c4_loads", {27'd0, loads}, 32'h1f);
    check("dmiss_c4_stall_cnt", bus.stall_cnt, PERF ? 32'd3 : 32'd0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    #1 check("dmiss_c5_loads", {27'd0, loads}, 32'h1f);

    // Early icache answer is remembered until dcache answers
    apply_reset();
    rst = 1'b1;
    next_cycle(); drive(1, 0, 1, 0, 0, 0);
    #1 check("split_c1_loads", {27'd0, loads}, 32'd0);
    next_cycle(); bus.imem_resp = 1'b1;
    #1 check("split_c2_loads", {27'd0, loads}, 32'd0);
    next_cycle(); bus.imem_resp = 1'b0;
    #1 check("split_c3_loads", {27'd0, loads}, 32'd0);
    next_cycle();
    #1 check("split_c4_loads", {27'd0, loads}, 32'd0);
    next_cycle(); bus.dmem_resp = 1'b1;
    #1 check("split_c5_loads", {27'd0, loads}, 32'h1f);
    next_cycle(); drive(1, 0, 0, 0, 0, 0);
    #1 check("split_c6_i_flag_cleared", {27'd0, loads}, 32'd0);
    // Simultaneous answers: advance, and no flag survives
    next_cycle(); drive(1, 1, 1, 1, 0, 0);
    #1 check("both_resp_loads", {27'd0, loads}, 32'h1f);
    next_cycle(); drive(1, 0, 1, 0, 0, 0);
    #1 check("both_resp_no_flags", {27'd0, loads}, 32'd0);

    // Load-use on an advance cycle, then hazards during a hold
    apply_reset();
    rst = 1'b1;
    next_cycle(); drive(0, 0, 0, 0, 1, 0);
    #1 check("lu_loads", {27'd0, loads}, 32'h07);
    check("lu_sel_ifid", {29'd0, bus.sel_ifid}, 32'd0);
    check("lu_bubbles", {30'd0, bubs}, 32'd1);
    check("lu_load_exmem", {31'd0, bus.load_exmem}, 32'd1);
    next_cycle(); drive(0, 0, 0, 0, 0, 0);
    #1 check("lu_bubble_cnt", bus.bubble_cnt, PERF ? 32'd1 : 32'd0);
    next_cycle(); drive(0, 0, 1, 0, 1, 1);
    #1 check("hold_hazard_loads", {27'd0, loads}, 32'd0);
    check("hold_hazard_bubbles", {30'd0, bubs}, 32'd0);
    next_cycle(); bus.dmem_resp = 1'b1;
    #1 check("late_br_loads", {27'd0, loads}, 32'h1f);
    check("late_br_bubbles", {30'd0, bubs}, 32'd3);
    next_cycle(); drive(0, 0, 0, 0, 0, 0);
    #1 check("late_br_flush_cnt", bus.flush_cnt, PERF ? 32'd1 : 32'd0);
    check("late_br_stall_cnt", bus.stall_cnt, PERF ? 32'd1 : 32'd0);

    // Mispredict overrides load-use
    apply_reset();
    rst = 1'b1;
    next_cycle(); drive(0, 0, 0, 0, 1, 1);
    #1 check("br_lu_load_pc", {31'd0, bus.load_pc}, 32'd1);
    check("br_lu_bubbles", {30'd0, bubs}, 32'd3);
    next_cycle(); drive(0, 0, 0, 0, 0, 0);
    #1 check("br_lu_flush_cnt", bus.flush_cnt, PERF ? 32'd1 : 32'd0);
    check("br_lu_bubble_cnt", bus.bubble_cnt, 32'd0);

    // Asynchronous reset in the middle of a WAIT with a pending icache flag
    apply_reset();
    rst = 1'b1;
    next_cycle(); drive(1, 1, 1, 0, 0, 0);
    #1 check("wait_c1_loads", {27'd0, loads}, 32'd0);
    next_cycle(); bus.imem_resp = 1'b0;
    #1 check("wait_c2_loads", {27'd0, loads}, 32'd0);
    #2 rst = 1'b0;
    bus.dmem_resp = 1'b1;
    #1 check("async_rst_loads", {27'd0, loads}, 32'd0);
    check("async_rst_bubbles", {30'd0, bubs}, 32'd0);
    check("async_rst_cnt", bus.stall_cnt | bus.flush_cnt | bus.bubble_cnt, 32'd0);
    next_cycle(); drive(1, 0, 0, 0, 0, 0); rst = 1'b1;
    #1 check("post_rst_init", {27'd0, loads}, 32'd0);
    next_cycle();
    #1 check("post_rst_flag_discarded", {27'd0, loads}, 32'd0);
    next_cycle(); bus.imem_resp = 1'b1;
    #1 check("post_rst_advance", {27'd0, loads}, 32'h1f);

    // Mixed traffic, checked by the model alone
    apply_reset();
    rst = 1'b1;
    for (int i = 0; i < NV; i++) begin
      next_cycle();
      drive(vec[i][5], vec[i][4], vec[i][3], vec[i][2], vec[i][1], vec[i][0]);
    end
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    next_cycle();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous and active-low; asserts immediately, releases synchronously to clk.
REQ-003 imem_read  input  1  IF has an instruction fetch outstanding.
REQ-004 imem_resp  input  1  icache response; valid for one cycle.
REQ-005 dmem_req  input  1  MEM-stage packet performs a load or store.
REQ-006 dmem_resp  input  1  dcache response; valid for one cycle.
REQ-007 load_use  input  1  ID instruction sources rd of a load currently in EX.
REQ-008 br_mispredict  input  1  EX resolved a redirect (taken branch/jump).
REQ-009 load_pc, load_ifid, load_idex, load_exmem, load_memwb  output  1 each  register enables.
REQ-010 sel_ifid, sel_idex, sel_exmem, sel_memwb  output  3 each  buffer_load_mux::buffer_sel_t (use_old=0, load_ifid=1, load_idex=2, load_exmem=3, load_memwb=4).
REQ-011 bubble_ifid, bubble_idex  output  1 each  upstream mux drives an all-zero packet into that buffer.
REQ-012 stall_cnt, flush_cnt, bubble_cnt  output  32 each  performance counters (see Configuration).

Function
REQ-013 FSM states: INIT, RUN, WAIT; state register plus sticky flags i_done, d_done.
REQ-014 i_ok = ~imem_read | imem_resp | i_done; d_ok = ~dmem_req | dmem_resp | d_done; advance = (state != INIT) & i_ok & d_ok.
REQ-015 INIT -> RUN unconditionally after one cycle; all outputs zero/use_old in INIT.
REQ-016 RUN -> WAIT when ~advance; WAIT -> RUN on the cycle advance is 1; RUN stays RUN while advance.
REQ-017 i_done set when imem_resp=1 and advance=0; d_done likewise with dmem_resp; both cleared on any advance cycle.
REQ-018 advance=0: all load_* = 0, all sel_* = use_old, bubbles = 0.
REQ-019 advance=1, no hazard: all load_* = 1, each sel_X = its own stage enum, bubbles = 0.
REQ-020 advance=1, load_use=1, br_mispredict=0: load_pc=0, load_ifid=0, sel_ifid=use_old; load_idex=1 with bubble_idex=1; EX/MEM, MEM/WB advance normally.
REQ-021 advance=1, br_mispredict=1: load_pc=1 (redirect), bubble_ifid=1, bubble_idex=1, all buffers load; overrides load_use.
REQ-022 br_mispredict or load_use asserted while advance=0 has no effect that cycle; honored on the advance cycle if still asserted.
REQ-023 Simultaneous imem_resp and dmem_resp with both outstanding: advance same cycle, flags stay clear.
REQ-024 sel_* outputs combinational from current state/inputs; no added latency.

Reset
REQ-025 rst=0: state=INIT, i_done=d_done=0, counters=0, all load_*=0, sel_*=use_old, bubbles=0, regardless of clk.
REQ-026 Reset during WAIT discards pending flags; first post-reset cycle is INIT.

Configuration
REQ-027 Macro PIPELINE_CTRL_PERF_EN: when defined, stall_cnt +1 each cycle advance=0 in RUN/WAIT, flush_cnt +1 per REQ-021 cycle, bubble_cnt +1 per REQ-020 cycle; all saturate at 32'hFFFF_FFFF.
REQ-028 Macro undefined: counters not implemented, outputs tied to 0.

Verification
REQ-029 Release reset, imem_read=1, imem_resp=1 every cycle -> cycle 0 INIT all loads 0; cycle 1 onward all loads 1, sel_idex=2.
REQ-030 dmem_req=1, dmem_resp at cycle 4 -> loads 0 for cycles 1-3, all loads 1 at cycle 4, stall_cnt=3 (PERF_EN).
REQ-031 imem_resp at cycle 2, dmem_resp at cycle 5, both outstanding from cycle 1 -> i_done=1 cycles 3-5, advance only at cycle 5, then i_done=0.
REQ-032 load_use=1 for one advance cycle -> load_pc=0, load_ifid=0, sel_ifid=0, bubble_idex=1, load_exmem=1; bubble_cnt=1.
REQ-033 load_use=1 and br_mispredict=1 together -> load_pc=1, bubble_ifid=1, bubble_idex=1, flush_cnt=1, bubble_cnt=0.
REQ-034 Drive rst=0 mid-WAIT between clock edges -> outputs zero immediately; counters 0; without PERF_EN counters read 0 throughout.
